// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential signed multiply/divide unit.
package multdiv_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam logic [DEFAULT_WIDTH-1:0] INT_MIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  typedef enum logic {OP_MULT, OP_DIV} op_t;
endpackage

// File: rtl/multdiv_iter_unit.sv
// One combinational step of the shared datapath: radix-2 shift-add (multiply)
// or restoring shift-subtract (divide) on the {acc, lo} register pair.
module multdiv_iter_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] accNext,
  output logic [WIDTH-1:0] loNext
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] remShift;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, operand};
    remShift = {acc, lo[WIDTH-1]};
    diff     = remShift - {1'b0, operand};
    if (op == OP_DIV) begin
      // Partial remainder stays below the divisor, so diff[WIDTH] is a clean borrow.
      if (diff[WIDTH]) begin
        accNext = remShift[WIDTH-1:0];
        loNext  = {lo[WIDTH-2:0], 1'b0};
      end else begin
        accNext = diff[WIDTH-1:0];
        loNext  = {lo[WIDTH-2:0], 1'b1};
      end
    end else if (lo[0]) begin
      {accNext, loNext} = {sum, lo[WIDTH-1:1]};
    end else begin
      {accNext, loNext} = {1'b0, acc, lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/multdiv_seq.sv
// Multicycle signed multiply/divide sequencer with fast-path divide faults.
// Optional MULTDIV_EARLY_TERM_EN: finish MULT once remaining multiplier bits are zero.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk_100mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam logic [WIDTH-1:0] MIN_VAL = {INT_MIN[DEFAULT_WIDTH-1], {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  state_t           state;
  op_t              op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc, lo, operand;
  logic             sign, excFast;

  logic [WIDTH-1:0]   magA, magB, accStep, loStep;
  logic               divFault, mulOvf;
  logic [2*WIDTH-1:0] prodSigned;
  logic [WIDTH-1:0]   quotSigned;

  multdiv_iter_unit #(.WIDTH(WIDTH)) iterUnit (
    .op      (op),
    .acc     (acc),
    .lo      (lo),
    .operand (operand),
    .accNext (accStep),
    .loNext  (loStep)
  );

  always_comb begin
    magA       = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    magB       = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    divFault   = (data_operandB == '0) || ((data_operandA == MIN_VAL) && (data_operandB == '1));
    prodSigned = sign ? -{acc, lo} : {acc, lo};
    quotSigned = sign ? -lo : lo;
    mulOvf     = !((&prodSigned[2*WIDTH-1:WIDTH-1]) || !(|prodSigned[2*WIDTH-1:WIDTH-1]));
  end

`ifdef MULTDIV_EARLY_TERM_EN
  logic [WIDTH-1:0]   pendingBits;
  logic [2*WIDTH-1:0] finalProd;

  // Multiplier bits not yet consumed sit in lo[WIDTH-1-count:0]; bit 0 is used this step.
  always_comb begin
    pendingBits = (lo & ({WIDTH{1'b1}} >> count)) >> 1;
    finalProd   = {accStep, loStep} >> (WIDTH - 1 - int'(count));
  end
`endif

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state          <= IDLE;
      op             <= OP_MULT;
      count          <= '0;
      acc            <= '0;
      lo             <= '0;
      operand        <= '0;
      sign           <= 1'b0;
      excFast        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        // A start always wins, including over an operation in flight.
        op      <= ctrl_MULT ? OP_MULT : OP_DIV;
        sign    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        count   <= '0;
        acc     <= '0;
        excFast <= 1'b0;
        busy    <= 1'b1;
        if (ctrl_MULT) begin
          lo      <= magB;
          operand <= magA;
          state   <= MULT;
`ifdef MULTDIV_EARLY_TERM_EN
          if (magB[WIDTH-1:1] == '0) begin
            lo    <= magB[0] ? magA : '0;
            state <= DONE;
          end
`endif
        end else begin
          lo      <= magA;
          operand <= magB;
          excFast <= divFault;
          state   <= divFault ? DONE : DIV;
        end
      end else begin
        case (state)
          IDLE: ;
          MULT, DIV: begin
            acc   <= accStep;
            lo    <= loStep;
            count <= count + CNT_W'(1);
            if (count == LAST) begin
              state <= DONE;
            end
`ifdef MULTDIV_EARLY_TERM_EN
            else if ((state == MULT) && (pendingBits == '0)) begin
              {acc, lo} <= finalProd;
              state     <= DONE;
            end
`endif
          end
          DONE: begin
            state          <= IDLE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            if (excFast) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else if (op == OP_MULT) begin
              data_result    <= prodSigned[WIDTH-1:0];
              data_exception <= mulOvf;
            end else begin
              data_result    <= quotSigned;
              data_exception <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed cases plus randomized operands
// checked against a plain-arithmetic reference.
module tb_multdiv_seq;
  import multdiv_pkg::*;

  localparam int W = 32;

  logic         clk_100mhz = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int tests = 0;
  int fails = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  multdiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_100mhz     (clk_100mhz),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic, divide truncating toward zero.
  task automatic refModel(input bit isMult, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic e);
    longint p;
    int sa, sb;
    sa = a;
    sb = b;
    if (isMult) begin
      p = longint'(sa) * longint'(sb);
      r = p[W-1:0];
      e = (p != longint'(int'(p[W-1:0])));
    end else if (b == '0 || (a == INT_MIN && b == '1)) begin
      r = '0;
      e = 1'b1;
    end else begin
      r = sa / sb;
      e = 1'b0;
    end
  endtask

  // Expected RDY latency in cycles after the start edge; -1 means data-dependent (1..33).
  function automatic int expLatency(input bit isMult, input logic [W-1:0] a, input logic [W-1:0] b);
    if (!isMult) return (b == '0 || (a == INT_MIN && b == '1)) ? 1 : 33;
`ifdef MULTDIV_EARLY_TERM_EN
    return (b == '0 || b == 32'd1 || b == '1) ? 1 : -1;
`else
    return 33;
`endif
  endfunction

  task automatic start(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk_100mhz);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clk_100mhz);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
  endtask

  // Called #1 after the start edge; lat=0 means no RDY within the budget.
  task automatic waitRdy(output int lat, output int busyCycles);
    lat = 0;
    busyCycles = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_100mhz);
      #1;
      if (data_resultRDY) begin
        lat = k;
        if (busy) busyCycles++;
        break;
      end
      if (busy) busyCycles++;
    end
  endtask

  task automatic runOp(input string tag, input bit m, input bit d,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] expR;
    logic expE;
    int lat, bc, expLat;
    refModel(m, a, b, expR, expE);
    expLat = expLatency(m, a, b);
    start(m, d, a, b);
    waitRdy(lat, bc);
    if (expLat >= 0) check({tag, " latency"}, 64'(lat), 64'(expLat));
    else check({tag, " latency in 1..33"}, 64'(lat >= 1 && lat <= 33), 64'd1);
    check({tag, " result"}, 64'(data_result), 64'(expR));
    check({tag, " exception"}, 64'(data_exception), 64'(expE));
    check({tag, " busy cycles"}, 64'(bc), 64'(lat));
    @(posedge clk_100mhz);
    #1;
    check({tag, " rdy pulse width"}, 64'(data_resultRDY), 64'd0);
    check({tag, " result held"}, 64'(data_result), 64'(expR));
  endtask

  initial begin
    int lat, bc, rdySeen;
    logic [W-1:0] a, b;
    bit m;

    repeat (3) @(posedge clk_100mhz);
    #1;
    check("reset result", 64'(data_result), 64'd0);
    check("reset exception", 64'(data_exception), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    @(negedge clk_100mhz);
    reset = 1'b0;

    runOp("mul 7*-3", 1, 0, 32'd7, -32'sd3);
    runOp("mul ovf", 1, 0, 32'h0001_0000, 32'h0001_0000);
    runOp("mul -1*-1", 1, 0, '1, '1);
    runOp("div -7/2", 0, 1, -32'sd7, 32'd2);
    runOp("div 100/7", 0, 1, 32'd100, 32'd7);
    runOp("div by zero", 0, 1, 32'd5, 32'd0);
    runOp("div min/-1", 0, 1, INT_MIN, '1);
    runOp("div min/1", 0, 1, INT_MIN, 32'd1);
    runOp("mul min*-1", 1, 0, INT_MIN, '1);
    runOp("mul 12345*1", 1, 0, 32'd12345, 32'd1);
    runOp("mul and div together", 1, 1, 32'd100, 32'd7);

    for (int i = 0; i < 16; i++) begin
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'($urandom_range(0, 20)) - 32'd10;
        2: b = '1;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = INT_MIN;
      runOp($sformatf("rand%0d", i), m, !m, a, b);
    end

    // Restart: DIV at E10 aborts MULT, single RDY 33 cycles later.
    start(1, 0, 32'd3, 32'd4);
    rdySeen = 0;
    repeat (9) begin
      @(posedge clk_100mhz);
      #1;
      if (data_resultRDY) rdySeen++;
    end
    start(0, 1, 32'd100, 32'd7);
    waitRdy(lat, bc);
    check("restart early rdy", 64'(rdySeen), 64'd0);
    check("restart latency", 64'(lat), 64'd33);
    check("restart result", 64'(data_result), 64'd14);
    check("restart exception", 64'(data_exception), 64'd0);

    // Reset at E15 of an operation.
    start(1, 0, 32'd1234, 32'd5678);
    repeat (14) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    reset = 1'b1;
    @(posedge clk_100mhz);
    #1;
    check("midreset result", 64'(data_result), 64'd0);
    check("midreset exception", 64'(data_exception), 64'd0);
    check("midreset rdy", 64'(data_resultRDY), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    @(negedge clk_100mhz);
    reset = 1'b0;
    rdySeen = 0;
    repeat (40) begin
      @(posedge clk_100mhz);
      #1;
      if (data_resultRDY) rdySeen++;
    end
    check("midreset no rdy", 64'(rdySeen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
